// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state type and the byte-wise CRC-32 step.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
  localparam int          ETH_MIN_LEN = 60;
  localparam int          ETH_MAX_LEN = 1514;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAD   = 3'd2,
    FCS   = 3'd3,
    DRAIN = 3'd4,
    IFG   = 3'd5
  } state_t;

  // Reflected CRC-32: fold one byte in, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// Frame feeder for the RMII transmit controller: forwards payload bytes, pads short
// frames, appends the FCS and holds off the next frame until busy drops plus the IFG.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int IFG_CYC = 48,
  parameter int GAP_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       tx_bz,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       frame_done,
  output logic       err_gap,
  output logic       err_long
);

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYC - 1);
  localparam logic [8:0]  GAP_L    = 9'(GAP_MAX);

  state_t      state_r;
  logic [10:0] cnt_r;
  logic [31:0] crc_r;
  logic [7:0]  ifg_r;
  logic [7:0]  gap_r;
  logic [1:0]  fcs_idx_r;

  logic        accept_s;
  logic [10:0] cnt_inc_s;
  logic [10:0] cnt_nxt_s;
  logic [8:0]  gap_inc_s;
  logic [31:0] crc_in_s;
  logic [31:0] crc_pad_s;
  logic [7:0]  fcs_byte_s;

  assign accept_s  = s_valid & s_ready;
  assign cnt_inc_s = cnt_r + 11'd1;
  // A byte offered at the saturated count is dropped and does not lengthen the frame.
  assign cnt_nxt_s = (cnt_r == MAX_L) ? cnt_r : cnt_inc_s;
  assign gap_inc_s = {1'b0, gap_r} + 9'd1;
  assign crc_in_s  = crc32_byte(crc_r, s_data);
  assign crc_pad_s = crc32_byte(crc_r, 8'h00);

  // Select the complemented CRC byte for the current FCS slot, LSB byte first.
  always_comb begin
    fcs_byte_s = 8'h00;
    case (fcs_idx_r)
      2'd0:    fcs_byte_s = ~crc_r[7:0];
      2'd1:    fcs_byte_s = ~crc_r[15:8];
      2'd2:    fcs_byte_s = ~crc_r[23:16];
      2'd3:    fcs_byte_s = ~crc_r[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  // Framing FSM with registered handshake, write strobe and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 11'd0;
      crc_r      <= CRC32_INIT;
      ifg_r      <= 8'd0;
      gap_r      <= 8'd0;
      fcs_idx_r  <= 2'd0;
      s_ready    <= 1'b0;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      err_gap    <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept_s) begin
            tx_data   <= s_data;
            tx_en     <= 1'b1;
            crc_r     <= crc32_byte(CRC32_INIT, s_data);
            cnt_r     <= 11'd1;
            gap_r     <= 8'd0;
            fcs_idx_r <= 2'd0;
            err_gap   <= 1'b0;
            err_long  <= 1'b0;
            if (s_last) begin
              s_ready <= 1'b0;
              state_r <= (11'd1 < MIN_L) ? PAD : FCS;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            gap_r <= 8'd0;
            if (cnt_r == MAX_L) begin
              err_long <= 1'b1;
            end else begin
              tx_data <= s_data;
              tx_en   <= 1'b1;
              crc_r   <= crc_in_s;
              cnt_r   <= cnt_inc_s;
            end
            if (s_last) begin
              s_ready <= 1'b0;
              state_r <= (cnt_nxt_s < MIN_L) ? PAD : FCS;
            end
          end else begin
            // Starvation watch: the controller may underrun if the feed stalls.
            gap_r <= gap_inc_s[8] ? gap_r : gap_inc_s[7:0];
            if (gap_inc_s >= GAP_L) begin
              err_gap <= 1'b1;
            end
          end
        end
        PAD: begin
          tx_data <= 8'h00;
          tx_en   <= 1'b1;
          crc_r   <= crc_pad_s;
          cnt_r   <= cnt_inc_s;
          if (cnt_inc_s >= MIN_L) begin
            state_r <= FCS;
          end
        end
        FCS: begin
          tx_data   <= fcs_byte_s;
          tx_en     <= 1'b1;
          fcs_idx_r <= fcs_idx_r + 2'd1;
          if (fcs_idx_r == 2'd3) begin
            frame_done <= 1'b1;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_bz) begin
            ifg_r <= 8'd0;
            if (IFG_CYC == 0) begin
              state_r <= IDLE;
              s_ready <= 1'b1;
              crc_r   <= CRC32_INIT;
              cnt_r   <= 11'd0;
            end else begin
              state_r <= IFG;
            end
          end
        end
        IFG: begin
          // Busy rising here means another writer claimed the controller.
          if (tx_bz) begin
            state_r <= DRAIN;
          end else if (ifg_r == IFG_LAST) begin
            state_r <= IDLE;
            s_ready <= 1'b1;
            crc_r   <= CRC32_INIT;
            cnt_r   <= 11'd0;
          end else begin
            ifg_r <= ifg_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
